// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_pkg
// Purpose : Shared encodings for the data-memory responder: load/store
//           control codes, FSM state enum and access-size helpers.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [2:0] {
        RD_NONE = 3'b000,
        RD_LB   = 3'b001,
        RD_LBU  = 3'b010,
        RD_LH   = 3'b011,
        RD_LHU  = 3'b100,
        RD_LW   = 3'b101,
        RD_LWU  = 3'b110,
        RD_LD   = 3'b111
    } rd_ctrl_e;

    typedef enum logic [2:0] {
        WR_NONE = 3'b000,
        WR_SB   = 3'b001,
        WR_SH   = 3'b010,
        WR_SW   = 3'b011,
        WR_SD   = 3'b100
    } wr_ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } dmem_state_e;

    // log2 of the access width in bytes
    function automatic logic [1:0] rd_size(input logic [2:0] rd);
        case (rd)
            RD_LB, RD_LBU: rd_size = 2'd0;
            RD_LH, RD_LHU: rd_size = 2'd1;
            RD_LW, RD_LWU: rd_size = 2'd2;
            default:       rd_size = 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] wr_size(input logic [2:0] wr);
        case (wr)
            WR_SB:   wr_size = 2'd0;
            WR_SH:   wr_size = 2'd1;
            WR_SW:   wr_size = 2'd2;
            default: wr_size = 2'd3;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lo);
        case (size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = lo[0];
            2'd2:    misaligned = |lo[1:0];
            default: misaligned = |lo;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_align.sv
`default_nettype none
// ============================================================================
// Module  : dmem_align
// Purpose : Combinational lane logic for the responder: store byte mask,
//           store data lane shift and load extraction with sign/zero extend.
// Ports   : i_addr_lo   - byte offset within the doubleword
//           i_rd_ctrl   - load type
//           i_wr_ctrl   - store type
//           i_din       - right-aligned store data
//           i_rdata     - doubleword read from storage
//           o_be        - per-byte write enable
//           o_wdata     - store data moved into its byte lanes
//           o_rdata_ext - extended load result
// Rev     : 1.0  initial release
// ============================================================================
module dmem_align
    import dmem_pkg::*;
(
    input  logic [2:0]  i_addr_lo,
    input  logic [2:0]  i_rd_ctrl,
    input  logic [2:0]  i_wr_ctrl,
    input  logic [63:0] i_din,
    input  logic [63:0] i_rdata,
    output logic [7:0]  o_be,
    output logic [63:0] o_wdata,
    output logic [63:0] o_rdata_ext
);

    logic [5:0]  w_shift;
    logic [7:0]  w_be_base;
    logic [63:0] w_lane;

    assign w_shift = {i_addr_lo, 3'b000};
    assign o_wdata = i_din << w_shift;
    assign w_lane  = i_rdata >> w_shift;

    always_comb begin
        w_be_base = 8'hFF;
        case (wr_size(i_wr_ctrl))
            2'd0:    w_be_base = 8'h01;
            2'd1:    w_be_base = 8'h03;
            2'd2:    w_be_base = 8'h0F;
            default: w_be_base = 8'hFF;
        endcase
    end

    assign o_be = (i_wr_ctrl == WR_NONE) ? 8'h00 : (w_be_base << i_addr_lo);

    always_comb begin
        o_rdata_ext = 64'd0;
        case (i_rd_ctrl)
            RD_LB:   o_rdata_ext = {{56{w_lane[7]}},  w_lane[7:0]};
            RD_LBU:  o_rdata_ext = {56'd0,            w_lane[7:0]};
            RD_LH:   o_rdata_ext = {{48{w_lane[15]}}, w_lane[15:0]};
            RD_LHU:  o_rdata_ext = {48'd0,            w_lane[15:0]};
            RD_LW:   o_rdata_ext = {{32{w_lane[31]}}, w_lane[31:0]};
            RD_LWU:  o_rdata_ext = {32'd0,            w_lane[31:0]};
            RD_LD:   o_rdata_ext = w_lane;
            default: o_rdata_ext = 64'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : dmem_responder
// Purpose : Single-outstanding data-memory responder with fixed access
//           latency, byte-granular stores and sign/zero-extended loads.
// Ports   : clk, rst (async, active-low)
//           dm_req, dm_addr, dm_din, dm_rd_ctrl, dm_wr_ctrl - request
//           dm_busy, dm_done, dm_dout, dm_err               - response
// Rev     : 1.0  initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_DW = 4096,
    parameter int LATENCY  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dm_req,
    input  logic [63:0] dm_addr,
    input  logic [63:0] dm_din,
    input  logic [2:0]  dm_rd_ctrl,
    input  logic [2:0]  dm_wr_ctrl,
    output logic        dm_busy,
    output logic        dm_done,
    output logic [63:0] dm_dout,
    output logic        dm_err
);

    localparam int         AW    = $clog2(DEPTH_DW);
    localparam logic [3:0] c_LAT = 4'(LATENCY);

    dmem_state_e r_state;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_idx;
    logic [2:0]    r_addr_lo;
    logic [2:0]    r_rd;
    logic [2:0]    r_wr;
    logic [63:0]   r_din;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic [63:0]   r_dout;

    logic [63:0]   r_mem [DEPTH_DW];

    logic          w_start;
    logic [1:0]    w_size;
    logic          w_reject;
    logic          w_last;
    logic          w_we;
    logic [7:0]    w_be;
    logic [63:0]   w_wdata;
    logic [63:0]   w_load;
    logic          w_unused_addr;

    // Address bits above the storage range are ignored so accesses wrap.
    assign w_unused_addr = &{1'b0, dm_addr[63:AW+3]};

    assign w_start  = dm_req && ((dm_rd_ctrl != RD_NONE) || (dm_wr_ctrl != WR_NONE));
    // Size comes from whichever control is active; if both are active the
    // request is rejected anyway.
    assign w_size   = (dm_wr_ctrl != WR_NONE) ? wr_size(dm_wr_ctrl) : rd_size(dm_rd_ctrl);
    assign w_reject = ((dm_rd_ctrl != RD_NONE) && (dm_wr_ctrl != WR_NONE))
                   || (dm_wr_ctrl > WR_SD)
                   || misaligned(w_size, dm_addr[2:0]);

    assign w_last = (r_state == ST_ACCESS) && (r_cnt == 4'd1);
    assign w_we   = w_last && (r_wr != WR_NONE);

    dmem_align u_align (
        .i_addr_lo   (r_addr_lo),
        .i_rd_ctrl   (r_rd),
        .i_wr_ctrl   (r_wr),
        .i_din       (r_din),
        .i_rdata     (r_mem[r_idx]),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_rdata_ext (w_load)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_idx     <= '0;
            r_addr_lo <= 3'd0;
            r_rd      <= 3'd0;
            r_wr      <= 3'd0;
            r_din     <= 64'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_dout    <= 64'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_idx     <= dm_addr[AW+2:3];
                        r_addr_lo <= dm_addr[2:0];
                        r_rd      <= dm_rd_ctrl;
                        r_wr      <= dm_wr_ctrl;
                        r_din     <= dm_din;
                        r_busy    <= 1'b1;
                        if (w_reject) begin
                            r_state <= ST_RESP;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                            r_dout  <= 64'd0;
                        end else begin
                            r_state <= ST_ACCESS;
                            r_cnt   <= c_LAT;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_RESP;
                        r_cnt   <= 4'd0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b0;
                        r_dout  <= (r_wr != WR_NONE) ? 64'd0 : w_load;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Storage is never cleared by reset; a write only happens in the last
    // ACCESS cycle, so a reset before then drops the store.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < 8; b++) begin
                if (w_be[b]) begin
                    r_mem[r_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    assign dm_busy = r_busy;
    assign dm_done = r_done;
    assign dm_err  = r_err;
    assign dm_dout = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_responder
// Purpose : Self-checking bench for dmem_responder against a byte-array
//           reference model; directed cases followed by random traffic.
// Rev     : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    localparam int DEPTH_DW = 64;
    localparam int LATENCY  = 2;
    localparam int NBYTES   = DEPTH_DW * 8;

    logic        clk;
    logic        rst;
    logic        dm_req;
    logic [63:0] dm_addr;
    logic [63:0] dm_din;
    logic [2:0]  dm_rd_ctrl;
    logic [2:0]  dm_wr_ctrl;
    logic        dm_busy;
    logic        dm_done;
    logic [63:0] dm_dout;
    logic        dm_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] m [NBYTES];

    dmem_responder #(.DEPTH_DW(DEPTH_DW), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rst        (rst),
        .dm_req     (dm_req),
        .dm_addr    (dm_addr),
        .dm_din     (dm_din),
        .dm_rd_ctrl (dm_rd_ctrl),
        .dm_wr_ctrl (dm_wr_ctrl),
        .dm_busy    (dm_busy),
        .dm_done    (dm_done),
        .dm_dout    (dm_dout),
        .dm_err     (dm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: byte-addressed little-endian memory, wraps at NBYTES.
    task automatic ref_access(input logic [2:0] rd, input logic [2:0] wr,
                              input logic [63:0] addr, input logic [63:0] din,
                              output logic err, output logic [63:0] dout);
        int n;
        int base;
        logic [63:0] v;
        if (wr != 0) n = (wr == 1) ? 1 : (wr == 2) ? 2 : (wr == 3) ? 4 : 8;
        else         n = (rd <= 2) ? 1 : (rd <= 4) ? 2 : (rd <= 6) ? 4 : 8;
        err  = (rd != 0 && wr != 0) || (wr > 4) || ((int'(addr[2:0]) % n) != 0);
        dout = 64'd0;
        base = int'(addr % 64'(NBYTES));
        if (!err && wr != 0) begin
            for (int i = 0; i < n; i++) m[base + i] = din[8*i +: 8];
        end else if (!err) begin
            v = 64'd0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = m[base + i];
            if ((rd == 1 || rd == 3 || rd == 5) && v[8*n-1])
                for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
            dout = v;
        end
    endtask

    // One complete transaction, checked for timing, error flag and data.
    task automatic do_req(input string tag, input logic [2:0] rd, input logic [2:0] wr,
                          input logic [63:0] addr, input logic [63:0] din,
                          output logic [63:0] got, output logic got_err);
        logic        e_err;
        logic [63:0] e_dout;
        int          n;
        bit          seen;
        ref_access(rd, wr, addr, din, e_err, e_dout);
        @(negedge clk);
        dm_req = 1'b1; dm_rd_ctrl = rd; dm_wr_ctrl = wr; dm_addr = addr; dm_din = din;
        @(posedge clk);
        #1;
        dm_req = 1'b0; dm_rd_ctrl = 3'd0; dm_wr_ctrl = 3'd0;
        n = 0; seen = 0;
        while (n < 20 && !seen) begin
            @(negedge clk);
            n++;
            if (n == 1) chk({tag, ".busy"}, 64'(dm_busy), 64'd1);
            if (dm_done) seen = 1;
        end
        chk({tag, ".lat"}, 64'(n), e_err ? 64'd1 : 64'(LATENCY + 1));
        chk({tag, ".err"}, 64'(dm_err), 64'(e_err));
        chk({tag, ".dout"}, dm_dout, e_dout);
        got = dm_dout; got_err = dm_err;
        @(negedge clk);
        chk({tag, ".done_pulse"}, 64'(dm_done), 64'd0);
        chk({tag, ".hold"}, dm_dout, e_dout);
        chk({tag, ".idle"}, 64'(dm_busy), 64'd0);
    endtask

    initial begin
        logic [63:0] d;
        logic        e;
        logic        e_err;
        logic [63:0] e_dout;
        int          dones;
        logic [2:0]  rd, wr;
        logic [63:0] a;
        int          k;

        rst = 1'b0; dm_req = 1'b0; dm_addr = 64'd0; dm_din = 64'd0;
        dm_rd_ctrl = 3'd0; dm_wr_ctrl = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst.busy", 64'(dm_busy), 64'd0);
        chk("rst.done", 64'(dm_done), 64'd0);
        chk("rst.err",  64'(dm_err),  64'd0);
        chk("rst.dout", dm_dout,      64'd0);
        rst = 1'b1;

        // Fill the whole storage so every later load has a known value.
        for (int i = 0; i < DEPTH_DW; i++)
            do_req("init", 3'd0, 3'd4, 64'(i * 8), {$urandom, $urandom}, d, e);

        do_req("sd10", 3'd0, 3'd4, 64'h10, 64'h1122334455667788, d, e);
        do_req("ld10", 3'd7, 3'd0, 64'h10, 64'd0, d, e);
        chk("ld10.val", d, 64'h1122334455667788);

        do_req("lb17", 3'd1, 3'd0, 64'h17, 64'd0, d, e);
        chk("lb17.val", d, 64'h11);
        do_req("sb17", 3'd0, 3'd1, 64'h17, 64'h80, d, e);
        do_req("lb17b", 3'd1, 3'd0, 64'h17, 64'd0, d, e);
        chk("lb17b.val", d, 64'hFFFFFFFFFFFFFF80);
        do_req("lbu17", 3'd2, 3'd0, 64'h17, 64'd0, d, e);
        chk("lbu17.val", d, 64'h80);

        do_req("sd10b", 3'd0, 3'd4, 64'h10, 64'h1122334455667788, d, e);
        do_req("sh14", 3'd0, 3'd2, 64'h14, 64'hBEEF, d, e);
        do_req("ld10c", 3'd7, 3'd0, 64'h10, 64'd0, d, e);
        chk("ld10c.val", d, 64'h1122BEEF55667788);

        do_req("lw12", 3'd5, 3'd0, 64'h12, 64'd0, d, e);
        chk("lw12.errflag", 64'(e), 64'd1);
        do_req("ldsd", 3'd7, 3'd4, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, d, e);
        chk("ldsd.errflag", 64'(e), 64'd1);
        do_req("swill", 3'd0, 3'd6, 64'h10, 64'h0, d, e);
        chk("swill.errflag", 64'(e), 64'd1);
        do_req("ld10d", 3'd7, 3'd0, 64'h10, 64'd0, d, e);
        chk("ld10d.val", d, 64'h1122BEEF55667788);

        // Reset during the first ACCESS cycle of a store: nothing written.
        @(negedge clk);
        dm_req = 1'b1; dm_wr_ctrl = 3'd3; dm_rd_ctrl = 3'd0;
        dm_addr = 64'h20; dm_din = 64'hDEADBEEF;
        @(posedge clk);
        #1;
        dm_req = 1'b0; dm_wr_ctrl = 3'd0;
        rst = 1'b0;
        #1;
        chk("arst.busy", 64'(dm_busy), 64'd0);
        chk("arst.done", 64'(dm_done), 64'd0);
        chk("arst.err",  64'(dm_err),  64'd0);
        chk("arst.dout", dm_dout,      64'd0);
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (dm_done) dones++;
            if (i == 1) rst = 1'b1;
        end
        chk("arst.nodone", 64'(dones), 64'd0);
        do_req("lw20", 3'd5, 3'd0, 64'h20, 64'd0, d, e);

        // A request held high through ACCESS/RESP yields a single completion.
        ref_access(3'd7, 3'd0, 64'h10, 64'd0, e_err, e_dout);
        @(negedge clk);
        dm_req = 1'b1; dm_rd_ctrl = 3'd7; dm_wr_ctrl = 3'd0; dm_addr = 64'h10;
        @(posedge clk);
        #1;
        dm_rd_ctrl = 3'd0; dm_wr_ctrl = 3'd4; dm_din = 64'hCAFE_F00D_0000_0001;
        dones = 0; k = 0;
        while (dm_req && k < 20) begin
            @(negedge clk);
            k++;
            if (dm_done) begin
                dones++;
                chk("hold.dout", dm_dout, e_dout);
            end
            if (!dm_busy) dm_req = 1'b0;
        end
        dm_wr_ctrl = 3'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (dm_done) dones++;
        end
        chk("hold.dones", 64'(dones), 64'd1);
        do_req("hold.ld", 3'd7, 3'd0, 64'h10, 64'd0, d, e);

        // Random traffic, including wrap-around addresses and idle requests.
        for (int t = 0; t < 200; t++) begin
            k  = int'($urandom_range(0, 9));
            rd = 3'd0; wr = 3'd0;
            if (k <= 4)      rd = 3'($urandom_range(1, 7));
            else if (k <= 7) wr = 3'($urandom_range(1, 4));
            else if (k == 8) begin
                if ($urandom_range(0, 1) == 1) wr = 3'($urandom_range(5, 7));
                else begin rd = 3'($urandom_range(1, 7)); wr = 3'($urandom_range(1, 4)); end
            end
            a = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a[2:0] = 3'd0;
            if (k == 9) begin
                @(negedge clk);
                dm_req = 1'b1; dm_rd_ctrl = 3'd0; dm_wr_ctrl = 3'd0; dm_addr = a;
                @(posedge clk);
                #1;
                dm_req = 1'b0;
                chk("rnd.noop", 64'(dm_busy), 64'd0);
            end else begin
                do_req("rnd", rd, wr, a, {$urandom, $urandom}, d, e);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
